// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared phase codes and default timings for the traffic signal phase sequencer.
// The phase code is driven straight onto the lamp demux selects as {sel0, sel1}.
package traffic_phase_ctrl_pkg;

   localparam int unsigned PHASE_W = 2;

   typedef enum logic [PHASE_W-1:0] {
      PH_RED    = 2'b00,
      PH_YELLOW = 2'b01,
      PH_GREEN  = 2'b10
   } phase_e;

   localparam int unsigned DEF_T_RED       = 5;
   localparam int unsigned DEF_T_GREEN     = 6;
   localparam int unsigned DEF_T_YELLOW    = 2;
   localparam int unsigned DEF_T_MIN_GREEN = 3;
   localparam int unsigned DEF_CNT_W       = 8;

endpackage

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// Loadable down-counter holding the ticks left in the current phase minus one.
// Load wins over decrement; the count saturates at zero.
module traffic_phase_ctrl_phase_timer #(
   parameter int unsigned      CNT_W   = 8,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero,
   output logic [CNT_W-1:0] count
);

   assign zero = (count == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= RST_VAL;
      end else if (load) begin
         count <= load_val;
      end else if (dec && !zero) begin
         count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Timed RED->GREEN->YELLOW phase sequencer for one signal head, advancing on tick,
// with a latched pedestrian request that cuts GREEN short and an enable that freezes it.
module traffic_phase_ctrl
   import traffic_phase_ctrl_pkg::*;
#(
   parameter int unsigned T_RED       = DEF_T_RED,
   parameter int unsigned T_GREEN     = DEF_T_GREEN,
   parameter int unsigned T_YELLOW    = DEF_T_YELLOW,
   parameter int unsigned T_MIN_GREEN = DEF_T_MIN_GREEN,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             en,
   input  logic             ped_req,
   output logic             lamp_en,
   output logic             sel0,
   output logic             sel1,
   output logic             ped_ack,
   output logic [CNT_W-1:0] remain
);

   localparam logic [CNT_W-1:0] LD_RED     = CNT_W'(T_RED - 1);
   localparam logic [CNT_W-1:0] LD_GREEN   = CNT_W'(T_GREEN - 1);
   localparam logic [CNT_W-1:0] LD_YELLOW  = CNT_W'(T_YELLOW - 1);
   // Timer value at or below which a pending request ends GREEN after T_MIN_GREEN ticks.
   localparam logic [CNT_W-1:0] GREEN_EXIT = CNT_W'(T_GREEN - T_MIN_GREEN);

   phase_e           state_q;
   phase_e           state_d;
   logic             ped_pend_q;
   logic             ped_pend_d;
   logic             ack_d;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_load_val;
   logic             tmr_dec;
   logic             tmr_zero;
   logic             tick_act;

   assign tick_act = tick & en;

   traffic_phase_ctrl_phase_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (LD_RED)
   ) u_phase_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero),
      .count    (remain)
   );

   // State, pending-request latch and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= PH_RED;
         ped_pend_q <= 1'b0;
         ped_ack    <= 1'b0;
         lamp_en    <= 1'b0;
         sel0       <= 1'b0;
         sel1       <= 1'b0;
      end else begin
         state_q    <= state_d;
         ped_pend_q <= ped_pend_d;
         ped_ack    <= ack_d;
         lamp_en    <= en;
         sel0       <= state_d[1];
         sel1       <= state_d[0];
      end
   end

   // Next-phase and timer control; the timer only moves on an enabled tick.
   always_comb begin
      state_d      = state_q;
      ped_pend_d   = ped_pend_q | ped_req;
      ack_d        = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      tmr_dec      = 1'b0;

      case (state_q)
         PH_RED: begin
            if (tick_act) begin
               if (tmr_zero) begin
                  state_d      = PH_GREEN;
                  tmr_load     = 1'b1;
                  tmr_load_val = LD_GREEN;
               end else begin
                  tmr_dec = 1'b1;
               end
            end
         end
         PH_GREEN: begin
            if (tick_act) begin
               if (tmr_zero || (ped_pend_q && (remain <= GREEN_EXIT))) begin
                  state_d      = PH_YELLOW;
                  tmr_load     = 1'b1;
                  tmr_load_val = LD_YELLOW;
               end else begin
                  tmr_dec = 1'b1;
               end
            end
         end
         PH_YELLOW: begin
            if (tick_act) begin
               if (tmr_zero) begin
                  state_d      = PH_RED;
                  tmr_load     = 1'b1;
                  tmr_load_val = LD_RED;
                  // A request on this same edge counts as served by this ack.
                  if (ped_pend_q) begin
                     ped_pend_d = 1'b0;
                     ack_d      = 1'b1;
                  end
               end else begin
                  tmr_dec = 1'b1;
               end
            end
         end
         default: begin
            state_d      = PH_RED;
            tmr_load     = 1'b1;
            tmr_load_val = LD_RED;
         end
      endcase
   end

endmodule
